axis_noc_ingress_buffer: RTL and testbench

- Per-port AXI-Stream flit buffer that sits directly upstream of a router_wrap input port (axis_in_* of one direction) and absorbs back-pressure from it.
- Stores up to DEPTH flits (tdata/tlast/tid/tdest) in a first-word-fall-through FIFO.
- Can run in cut-through mode or in store-and-forward mode, where a packet is presented only once its tlast flit is buffered.
- Exposes occupancy and a buffered-packet count for NoC monitoring.

---
 rtl/axis_noc_ingress_buffer.sv | 99 +++++++++
 tb/tb_axis_noc_ingress_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_noc_ingress_buffer.sv
// rtl/axis_noc_ingress_buffer.sv - AXI-Stream flit buffer ahead of a NoC router input port
module axis_noc_ingress_buffer #(
  parameter int TDATA_WIDTH       = 32,
  parameter int TID_WIDTH         = 2,
  parameter int TDEST_WIDTH       = 4,
  parameter int DEPTH             = 4,
  parameter int STORE_AND_FORWARD = 0,
  parameter int LVL_W             = $clog2(DEPTH + 1)
) (
  input  logic                   clk_usr,
  input  logic                   rst_n,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic                   axis_in_tlast,
  input  logic [TID_WIDTH-1:0]   axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic [LVL_W-1:0]       fill_level,
  output logic [LVL_W-1:0]       pkt_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;

  typedef enum logic {WAIT, SEND} state_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             ready_en;
  state_t           state, state_nxt;
  logic             wr_en, rd_en, full, empty;
  logic [ENT_W-1:0] head;

  assign full           = (fill_level == LVL_W'(DEPTH));
  assign empty          = (fill_level == '0);
  assign axis_in_tready = ready_en && !full;
  assign wr_en          = axis_in_tvalid && axis_in_tready;
  assign rd_en          = axis_out_tvalid && axis_out_tready;

  // Fields are forced to zero when empty so stale entries never leak out.
  assign head = empty ? '0 : mem[rd_ptr];
  assign {axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest} = head;

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
      state      <= WAIT;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      if (wr_en) begin
        mem[wr_ptr] <= {axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + LVL_W'(1);
        2'b01:   fill_level <= fill_level - LVL_W'(1);
        default: fill_level <= fill_level;
      endcase
      case ({wr_en && axis_in_tlast, rd_en && axis_out_tlast})
        2'b10:   pkt_count <= pkt_count + LVL_W'(1);
        2'b01:   pkt_count <= pkt_count - LVL_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // In WAIT a full buffer releases anyway so packets longer than DEPTH cannot deadlock.
  always_comb begin
    state_nxt       = state;
    axis_out_tvalid = !empty;
    if (STORE_AND_FORWARD != 0) begin
      case (state)
        WAIT: begin
          axis_out_tvalid = (pkt_count != '0) || full;
          if (axis_out_tvalid && axis_out_tready && !axis_out_tlast) state_nxt = SEND;
        end
        SEND: begin
          axis_out_tvalid = !empty;
          if (axis_out_tvalid && axis_out_tready && axis_out_tlast) state_nxt = WAIT;
        end
        default: state_nxt = WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_noc_ingress_buffer.sv
// tb/tb_axis_noc_ingress_buffer.sv - scoreboard bench for cut-through and store-and-forward buffers
module tb_axis_noc_ingress_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a_* : cut-through instance, b_* : store-and-forward instance
  logic        a_in_tvalid = 0, a_in_tready, a_in_tlast = 0;
  logic [31:0] a_in_tdata = 0;
  logic [1:0]  a_in_tid = 0;
  logic [3:0]  a_in_tdest = 0;
  logic        a_out_tvalid, a_out_tready = 0, a_out_tlast;
  logic [31:0] a_out_tdata;
  logic [1:0]  a_out_tid;
  logic [3:0]  a_out_tdest;
  logic [2:0]  a_fill, a_pkt;

  logic        b_in_tvalid = 0, b_in_tready, b_in_tlast = 0;
  logic [31:0] b_in_tdata = 0;
  logic [1:0]  b_in_tid = 0;
  logic [3:0]  b_in_tdest = 0;
  logic        b_out_tvalid, b_out_tready = 0, b_out_tlast;
  logic [31:0] b_out_tdata;
  logic [1:0]  b_out_tid;
  logic [3:0]  b_out_tdest;
  logic [2:0]  b_fill, b_pkt;

  axis_noc_ingress_buffer #(.DEPTH(4), .STORE_AND_FORWARD(0)) dut_a (
    .clk_usr(clk), .rst_n(rst_n),
    .axis_in_tvalid(a_in_tvalid), .axis_in_tready(a_in_tready), .axis_in_tdata(a_in_tdata),
    .axis_in_tlast(a_in_tlast), .axis_in_tid(a_in_tid), .axis_in_tdest(a_in_tdest),
    .axis_out_tvalid(a_out_tvalid), .axis_out_tready(a_out_tready), .axis_out_tdata(a_out_tdata),
    .axis_out_tlast(a_out_tlast), .axis_out_tid(a_out_tid), .axis_out_tdest(a_out_tdest),
    .fill_level(a_fill), .pkt_count(a_pkt));

  axis_noc_ingress_buffer #(.DEPTH(4), .STORE_AND_FORWARD(1)) dut_b (
    .clk_usr(clk), .rst_n(rst_n),
    .axis_in_tvalid(b_in_tvalid), .axis_in_tready(b_in_tready), .axis_in_tdata(b_in_tdata),
    .axis_in_tlast(b_in_tlast), .axis_in_tid(b_in_tid), .axis_in_tdest(b_in_tdest),
    .axis_out_tvalid(b_out_tvalid), .axis_out_tready(b_out_tready), .axis_out_tdata(b_out_tdata),
    .axis_out_tlast(b_out_tlast), .axis_out_tid(b_out_tid), .axis_out_tdest(b_out_tdest),
    .fill_level(b_fill), .pkt_count(b_pkt));

  logic [38:0] exp_a[$];
  logic [38:0] exp_b[$];
  logic        stream_a = 0;
  int          beats_a = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && a_out_tvalid && a_out_tready) begin
      beats_a++;
      if (exp_a.size() == 0) chk("a_unexpected_beat", {32'b0, a_out_tdata}, 64'hdead);
      else chk("a_flit", {25'b0, a_out_tdata, a_out_tlast, a_out_tid, a_out_tdest}, {25'b0, exp_a.pop_front()});
    end
    if (rst_n && stream_a) chk("a_stream_fill_le1", {63'b0, a_fill <= 3'd1}, 64'd1);
  end

  always @(negedge clk) begin
    if (rst_n && b_out_tvalid && b_out_tready) begin
      if (exp_b.size() == 0) chk("b_unexpected_beat", {32'b0, b_out_tdata}, 64'hdead);
      else chk("b_flit", {25'b0, b_out_tdata, b_out_tlast, b_out_tid, b_out_tdest}, {25'b0, exp_b.pop_front()});
    end
  end

  task automatic push_a(input logic [31:0] d, input logic l);
    int n = 0;
    a_in_tvalid = 1; a_in_tdata = d; a_in_tlast = l; a_in_tid = d[1:0]; a_in_tdest = d[7:4];
    @(negedge clk);
    while (!a_in_tready && n < 100) begin @(negedge clk); n++; end
    if (!a_in_tready) chk("a_push_timeout", 64'd0, 64'd1);
    else exp_a.push_back({d, l, d[1:0], d[7:4]});
    @(posedge clk); #1;
    a_in_tvalid = 0;
  endtask

  task automatic push_b(input logic [31:0] d, input logic l);
    int n = 0;
    b_in_tvalid = 1; b_in_tdata = d; b_in_tlast = l; b_in_tid = d[1:0]; b_in_tdest = d[7:4];
    @(negedge clk);
    while (!b_in_tready && n < 100) begin @(negedge clk); n++; end
    if (!b_in_tready) chk("b_push_timeout", 64'd0, 64'd1);
    else exp_b.push_back({d, l, d[1:0], d[7:4]});
    @(posedge clk); #1;
    b_in_tvalid = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(posedge clk); #1;
    while ((a_fill != 0 || b_fill != 0 || exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(name, {59'b0, a_fill, exp_a.size() != 0, exp_b.size() != 0} | {61'b0, b_fill}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", {63'b0, a_in_tready}, 64'd0);
    chk("rst_tvalid", {62'b0, a_out_tvalid, b_out_tvalid}, 64'd0);
    chk("rst_tdata", {a_out_tdata, b_out_tdata}, 64'd0);
    chk("rst_levels", {52'b0, a_fill, a_pkt, b_fill, b_pkt}, 64'd0);
    rst_n = 1;
    #1 chk("tready_before_edge", {63'b0, a_in_tready}, 64'd0);
    @(posedge clk); #1;
    chk("tready_after_edge", {62'b0, a_in_tready, b_in_tready}, 64'd3);
    chk("tvalid_after_edge", {63'b0, a_out_tvalid}, 64'd0);

    // Cut-through streaming
    a_out_tready = 1;
    stream_a = 1;
    beats_a = 0;
    for (int i = 1; i <= 8; i++) push_a(i, i == 8);
    chk("ct_first_latency", {63'b0, a_out_tvalid}, 64'd1);
    @(posedge clk); #1;
    chk("ct_beats_no_bubble", beats_a, 64'd8);
    stream_a = 0;
    drain("ct_drain");

    // Full and back-pressure
    a_out_tready = 0;
    for (int i = 1; i <= 4; i++) push_a(i, i == 4);
    chk("full_tready", {63'b0, a_in_tready}, 64'd0);
    chk("full_level", {61'b0, a_fill}, 64'd4);
    chk("full_pkt", {61'b0, a_pkt}, 64'd1);
    fork
      push_a(32'h5, 1'b1);
      begin repeat (2) @(posedge clk); #1 a_out_tready = 1; end
    join
    drain("bp_drain");

    // Store-and-forward: 3-flit packet
    b_out_tready = 1;
    push_b(32'h11, 0);
    chk("saf_gate1", {63'b0, b_out_tvalid}, 64'd0);
    push_b(32'h12, 0);
    chk("saf_gate2", {63'b0, b_out_tvalid}, 64'd0);
    push_b(32'h13, 1);
    chk("saf_release", {63'b0, b_out_tvalid}, 64'd1);
    chk("saf_pkt1", {61'b0, b_pkt}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("saf_consecutive", {63'b0, b_out_tvalid}, 64'd1);
    end
    @(posedge clk); #1;
    chk("saf_done", {60'b0, b_out_tvalid, b_pkt}, 64'd0);

    // Forced release with a 6-flit packet
    b_out_tready = 0;
    for (int i = 1; i <= 3; i++) push_b(32'h40 + i, 0);
    chk("fr_gate", {63'b0, b_out_tvalid}, 64'd0);
    push_b(32'h44, 0);
    chk("fr_valid_full", {60'b0, b_out_tvalid, b_fill}, {60'b0, 1'b1, 3'd4});
    b_out_tready = 1;
    push_b(32'h45, 0);
    push_b(32'h46, 1);
    drain("fr_drain");
    push_b(32'h77, 0);
    chk("fr_back_in_wait", {63'b0, b_out_tvalid}, 64'd0);
    @(posedge clk); #1;
    chk("fr_wait_hold", {63'b0, b_out_tvalid}, 64'd0);
    push_b(32'h78, 1);
    drain("fr_tail_drain");

    // Mid-packet asynchronous reset
    a_out_tready = 0;
    push_a(32'h21, 0);
    push_a(32'h22, 1);
    chk("mr_pre_levels", {58'b0, a_fill, a_pkt}, {58'b0, 3'd2, 3'd1});
    #2 rst_n = 0;
    #1;
    chk("mr_async_clear", {57'b0, a_out_tvalid, a_fill, a_pkt}, 64'd0);
    chk("mr_tready", {63'b0, a_in_tready}, 64'd0);
    exp_a.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    a_out_tready = 1;
    push_a(32'h31, 0);
    push_a(32'h32, 0);
    push_a(32'h33, 1);
    drain("mr_after_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
